// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator: one client command becomes one AW/W/B or AR/R burst.
// Define AXI4_MST_4K_CHECK_EN to reject bursts that would cross a 4KB boundary (done_resp=SLVERR, no bus traffic).
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_data_last,
  input  logic                  rd_data_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic                  rlast_err_q, rlast_err_d;
  logic                  done_q, done_d;
  logic [1:0]            done_resp_q, done_resp_d;
  logic [1:0]            rresp_merged;
  logic                  rlast_bad;
`ifdef AXI4_MST_4K_CHECK_EN
  logic [13:0]           burst_end;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      resp_q      <= 2'b00;
      rlast_err_q <= 1'b0;
      done_q      <= 1'b0;
      done_resp_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      rlast_err_q <= rlast_err_d;
      done_q      <= done_d;
      done_resp_q <= done_resp_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    rlast_err_d  = rlast_err_q;
    done_d       = 1'b0;
    done_resp_d  = done_resp_q;
    // SLVERR dominates; otherwise the first non-OKAY response sticks
    rresp_merged = (resp_q == 2'b10 || RRESP == 2'b10) ? 2'b10 :
                   (resp_q != 2'b00) ? resp_q : RRESP;
    rlast_bad    = rlast_err_q | (RLAST != (cnt_q == 8'd0));
`ifdef AXI4_MST_4K_CHECK_EN
    burst_end    = {2'b00, cmd_addr[11:2], 2'b00} + {4'b0000, cmd_len, 2'b00} + 14'd4;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d      = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          len_d       = cmd_len;
          cnt_d       = cmd_len;
          resp_d      = 2'b00;
          rlast_err_d = 1'b0;
`ifdef AXI4_MST_4K_CHECK_EN
          if (burst_end > 14'd4096) begin
            done_d      = 1'b1;
            done_resp_d = 2'b10;
          end else begin
            state_d = cmd_write ? S_AW : S_AR;
          end
`else
          state_d = cmd_write ? S_AW : S_AR;
`endif
        end
      end
      S_AW: if (AWREADY) state_d = S_W;
      S_AR: if (ARREADY) state_d = S_R;
      S_W: begin
        if (wr_data_valid && WREADY) begin
          if (cnt_q == 8'd0) state_d = S_B;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      S_B: begin
        if (BVALID) begin
          done_d      = 1'b1;
          done_resp_d = BRESP;
          state_d     = S_IDLE;
        end
      end
      S_R: begin
        if (RVALID && rd_data_ready) begin
          resp_d      = rresp_merged;
          rlast_err_d = rlast_bad;
          if (cnt_q == 8'd0) begin
            done_d      = 1'b1;
            done_resp_d = rlast_bad ? 2'b10 : rresp_merged;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state_q == S_IDLE) && !ARESET;
    busy          = (state_q != S_IDLE);
    done          = done_q;
    done_resp     = done_resp_q;
    AWADDR        = addr_q;
    AWLEN         = len_q;
    AWSIZE        = 3'b010;
    AWVALID       = (state_q == S_AW);
    ARADDR        = addr_q;
    ARLEN         = len_q;
    ARSIZE        = 3'b010;
    ARVALID       = (state_q == S_AR);
    WVALID        = (state_q == S_W) && wr_data_valid;
    WDATA         = (state_q == S_W) ? wr_data : '0;
    WLAST         = (state_q == S_W) && (cnt_q == 8'd0);
    wr_data_ready = (state_q == S_W) && WREADY;
    BREADY        = (state_q == S_B);
    RREADY        = (state_q == S_R) && rd_data_ready;
    rd_data       = RDATA;
    rd_data_valid = (state_q == S_R) && RVALID;
    rd_data_last  = rd_data_valid && (cnt_q == 8'd0);
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: the bench acts as both client and AXI4 slave.
module tb_axi4_burst_master;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data, rd_data, WDATA, RDATA;
  logic        wr_data_valid, wr_data_ready, rd_data_valid, rd_data_last, rd_data_ready;
  logic        done, busy;
  logic [1:0]  done_resp, BRESP, RRESP;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_last(rd_data_last),
    .rd_data_ready(rd_data_ready),
    .done(done), .done_resp(done_resp), .busy(busy),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // abort >= 0 raises ARESET while that write beat is being offered
  task automatic do_write(input logic [15:0] a, input logic [7:0] l, input logic [1:0] br,
                          input logic [1:0] er, input int abort);
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    #1 chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    chk("awvalid", 32'(AWVALID), 32'd1);
    chk("awaddr", 32'(AWADDR), 32'({a[15:2], 2'b00}));
    chk("awlen", 32'(AWLEN), 32'(l));
    chk("awsize", 32'(AWSIZE), 32'd2);
    chk("wr_busy", 32'(busy), 32'd1);
    @(negedge ACLK);
    for (int i = 0; i <= int'(l); i++) begin
      wr_data = 32'hA0 + 32'(i); wr_data_valid = 1'b1;
      if (i == abort) begin
        ARESET = 1'b1;
        #1;
        chk("rst_awvalid", 32'(AWVALID), 32'd0);
        chk("rst_wvalid", 32'(WVALID), 32'd0);
        chk("rst_wlast", 32'(WLAST), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        wr_data_valid = 1'b0;
        @(negedge ACLK);
        chk("rst_done_held", 32'(done), 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_done_after", 32'(done), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        return;
      end
      #1;
      chk("wvalid", 32'(WVALID), 32'd1);
      chk("wdata", WDATA, 32'hA0 + 32'(i));
      chk("wlast", 32'(WLAST), 32'(i == int'(l)));
      chk("wr_data_ready", 32'(wr_data_ready), 32'd1);
      @(negedge ACLK);
    end
    wr_data_valid = 1'b0;
    #1;
    chk("bready", 32'(BREADY), 32'd1);
    chk("wvalid_after", 32'(WVALID), 32'd0);
    BVALID = 1'b1; BRESP = br;
    @(negedge ACLK);
    BVALID = 1'b0; BRESP = 2'b00;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_done_resp", 32'(done_resp), 32'(er));
    chk("wr_idle", 32'(busy), 32'd0);
    @(negedge ACLK);
    chk("wr_done_pulse", 32'(done), 32'd0);
  endtask

  // slave raises RLAST on beat index lastbeat
  task automatic do_read(input logic [15:0] a, input logic [7:0] l, input int lastbeat,
                         input bit toggle, input logic [1:0] er);
    int beat;
    int cyc;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
    #1 chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    chk("arvalid", 32'(ARVALID), 32'd1);
    chk("araddr", 32'(ARADDR), 32'({a[15:2], 2'b00}));
    chk("arlen", 32'(ARLEN), 32'(l));
    chk("arsize", 32'(ARSIZE), 32'd2);
    chk("rd_awvalid", 32'(AWVALID), 32'd0);
    @(negedge ACLK);
    beat = 0; cyc = 0;
    while (beat <= int'(l) && cyc < 64) begin
      rd_data_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      RVALID = 1'b1; RDATA = 32'hA0 + 32'(beat); RLAST = (beat == lastbeat); RRESP = 2'b00;
      #1;
      chk("rready", 32'(RREADY), 32'(rd_data_ready));
      chk("rd_data_valid", 32'(rd_data_valid), 32'd1);
      if (rd_data_ready) begin
        chk("rd_data", rd_data, 32'hA0 + 32'(beat));
        chk("rd_data_last", 32'(rd_data_last), 32'(beat == int'(l)));
        beat++;
      end
      @(negedge ACLK);
      cyc++;
    end
    RVALID = 1'b0; RLAST = 1'b0; rd_data_ready = 1'b0;
    chk("rd_beats", 32'(beat), 32'(int'(l) + 1));
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_done_resp", 32'(done_resp), 32'(er));
    chk("rd_idle", 32'(busy), 32'd0);
    @(negedge ACLK);
    chk("rd_done_pulse", 32'(done), 32'd0);
  endtask

`ifdef AXI4_MST_4K_CHECK_EN
  task automatic do_reject(input logic [15:0] a, input logic [7:0] l);
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    #1 chk("rej_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    chk("rej_awvalid", 32'(AWVALID), 32'd0);
    chk("rej_done", 32'(done), 32'd1);
    chk("rej_done_resp", 32'(done_resp), 32'd2);
    chk("rej_busy", 32'(busy), 32'd0);
    @(negedge ACLK);
    chk("rej_done_pulse", 32'(done), 32'd0);
  endtask
`endif

  initial begin
    ARESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_data_valid = 1'b0; rd_data_ready = 1'b0;
    AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
    BRESP = 2'b00; BVALID = 1'b0;
    RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("reset_awvalid", 32'(AWVALID), 32'd0);
    chk("reset_arvalid", 32'(ARVALID), 32'd0);
    chk("reset_wvalid", 32'(WVALID), 32'd0);
    chk("reset_wlast", 32'(WLAST), 32'd0);
    chk("reset_bready", 32'(BREADY), 32'd0);
    chk("reset_awaddr", 32'(AWADDR), 32'd0);
    chk("reset_awsize", 32'(AWSIZE), 32'd2);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_done_resp", 32'(done_resp), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

    do_write(16'h0010, 8'd3, 2'b00, 2'b00, -1);
    do_read(16'h0010, 8'd3, 3, 1'b1, 2'b00);
`ifdef AXI4_MST_4K_CHECK_EN
    do_reject(16'hFFF0, 8'd7);
`else
    do_write(16'hFFF0, 8'd7, 2'b10, 2'b10, -1);
`endif
    do_read(16'h0040, 8'd3, 1, 1'b0, 2'b10);
    do_write(16'h0100, 8'd7, 2'b00, 2'b00, 1);
    do_write(16'h0022, 8'd3, 2'b00, 2'b00, -1);
`ifdef AXI4_MST_4K_CHECK_EN
    do_reject(16'h0FF8, 8'd3);
`else
    do_write(16'h0FF8, 8'd3, 2'b00, 2'b00, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
